scc_mem_bridge: RTL and testbench

//  Parametrised bridge between the scc core and a single-port unified instruction/data memory.

---
 rtl/scc_pkg.sv | 20 ++
 rtl/scc_rr_arbiter.sv | 44 ++++
 rtl/scc_mem_bridge.sv | 164 ++++++++++++++++
 tb/tb_scc_mem_bridge.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scc_pkg.sv
// rtl/scc_pkg.sv - shared types and constants for the scc memory bridge
// Purpose: bridge FSM state encoding, err_bits indices and channel ids.
// Ports: none (package).
package scc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_HALTED
  } state_t;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;

  localparam logic CH_FETCH = 1'b0;
  localparam logic CH_DATA  = 1'b1;

endpackage

// File: rtl/scc_rr_arbiter.sv
// rtl/scc_rr_arbiter.sv - two-requester fixed-priority / round-robin arbiter
// Purpose: picks fetch or data channel; remembers the last accepted grant.
// Ports:
//   clk, rst, clk_en   clock, sync active-high reset, clock enable
//   if_req, d_req      pending requests
//   accept             the bridge takes the current grant this cycle
//   grant_any          at least one request pending
//   grant_ch           chosen channel (CH_FETCH / CH_DATA)
module scc_rr_arbiter
  import scc_pkg::*;
#(
  parameter int DATA_FIRST = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic if_req,
  input  logic d_req,
  input  logic accept,
  output logic grant_any,
  output logic grant_ch
);

  logic last_ch;

  always_comb begin
    grant_any = if_req | d_req;
    if (if_req && d_req) begin
      // Contention: fixed data priority, or hand the grant to whoever lost last time.
      grant_ch = (DATA_FIRST != 0) ? CH_DATA : ~last_ch;
    end else begin
      grant_ch = d_req ? CH_DATA : CH_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ch <= CH_FETCH;
    end else if (clk_en && accept) begin
      last_ch <= grant_ch;
    end
  end

endmodule

// File: rtl/scc_mem_bridge.sv
// rtl/scc_mem_bridge.sv - scc core to single-port unified memory bridge
// Purpose: arbitrates fetch and data requests onto one memory port with MEM_LAT read
//   latency, flags misaligned / out-of-range accesses, stops issuing after halt.
// Ports:
//   clk, rst, clk_en, halt                       control
//   if_req, if_addr -> if_rdata, if_valid        fetch channel
//   d_req, d_we, d_addr, d_wdata -> d_rdata, d_valid   data channel
//   mem_addr, mem_read, mem_write, mem_wdata, mem_rdata  memory port
//   err_bits (sticky), halted                    status
module scc_mem_bridge
  import scc_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int MEM_WORDS  = 1024,
  parameter int DATA_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        err_bits,
  output logic              halted
);

  localparam int                BYTES    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W + 1)'(MEM_WORDS * BYTES);
  localparam logic [3:0]        LAT_LOAD = 4'(MEM_LAT - 1);

  state_t            state, state_n;
  logic [3:0]        lat_cnt;
  logic              gnt_ch, we_q, halt_seen;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, if_rdata_q, d_rdata_q;
  logic [1:0]        err_q;

  logic              grant_any, grant_ch, accept, capture;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we, misalign, oor;

  scc_rr_arbiter #(.DATA_FIRST(DATA_FIRST)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .if_req   (if_req),
    .d_req    (d_req),
    .accept   (accept),
    .grant_any(grant_any),
    .grant_ch (grant_ch)
  );

  assign sel_addr = (grant_ch == CH_DATA) ? d_addr : if_addr;
  assign sel_we   = (grant_ch == CH_DATA) && d_we;
  assign misalign = |(sel_addr & OFF_MASK);
  assign oor      = {1'b0, sel_addr} >= LIMIT;

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    capture   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if_valid  = 1'b0;
    d_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (halt) begin
          state_n = ST_HALTED;
        end else if (grant_any) begin
          accept  = 1'b1;
          // A faulting access never reaches the memory; it just reports back.
          state_n = (misalign || oor) ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_read  = ~we_q;
        mem_write = we_q;
        if (MEM_LAT == 1) begin
          capture = 1'b1;
          state_n = ST_RESP;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The counter is about to reach zero: read data is valid at this edge.
        if (lat_cnt == 4'd1) begin
          capture = 1'b1;
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        if_valid = (gnt_ch == CH_FETCH);
        d_valid  = (gnt_ch == CH_DATA);
        state_n  = (halt_seen || halt) ? ST_HALTED : ST_IDLE;
      end
      ST_HALTED: state_n = ST_HALTED;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      lat_cnt    <= 4'd0;
      gnt_ch     <= CH_FETCH;
      we_q       <= 1'b0;
      halt_seen  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      err_q      <= 2'b00;
    end else if (clk_en) begin
      state <= state_n;
      if (accept) begin
        gnt_ch    <= grant_ch;
        we_q      <= sel_we;
        addr_q    <= sel_addr;
        wdata_q   <= d_wdata;
        halt_seen <= 1'b0;
        if (misalign) err_q[ERR_MISALIGN] <= 1'b1;
        if (oor)      err_q[ERR_RANGE]    <= 1'b1;
        // Faulting reads return zero; d_rdata is never touched by writes.
        if ((misalign || oor) && !sel_we) begin
          if (grant_ch == CH_DATA) d_rdata_q  <= '0;
          else                     if_rdata_q <= '0;
        end
      end
      if (state == ST_ISSUE || state == ST_WAIT) halt_seen <= halt_seen | halt;
      if (state == ST_ISSUE)      lat_cnt <= LAT_LOAD;
      else if (state == ST_WAIT)  lat_cnt <= lat_cnt - 4'd1;
      if (capture && !we_q) begin
        if (gnt_ch == CH_DATA) d_rdata_q  <= mem_rdata;
        else                   if_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err_bits  = err_q;
  assign halted    = (state == ST_HALTED);

endmodule

// File: tb/tb_scc_mem_bridge.sv
// tb/tb_scc_mem_bridge.sv - self-checking bench for scc_mem_bridge
// Instance 0: MEM_LAT=3, DATA_FIRST=1. Instance 1: MEM_LAT=1, DATA_FIRST=0.
module tb_scc_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, clk_en, halt, if_req, d_req, d_we;
  logic [1:0][31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [1:0][31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0]       if_valid, d_valid, mem_read, mem_write, halted;
  logic [1:0][1:0]  err_bits;

  logic [31:0] mem [1024];
  logic        mem_init;

  typedef struct {
    int          inst;
    logic        ch;
    logic [31:0] data;
    logic        chk;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int strobes [2] = '{0, 0};
  int k, s0;

  function automatic logic [31:0] pat(int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'hA5000000 ^ (32'(i) * 32'h00010001);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 3 : 1;
    localparam int DF  = (g == 0) ? 1 : 0;

    scc_mem_bridge #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MEM_WORDS(1024), .DATA_FIRST(DF)
    ) dut (
      .clk(clk), .rst(rst[g]), .clk_en(clk_en[g]), .halt(halt[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_valid(if_valid[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]), .d_valid(d_valid[g]),
      .mem_addr(mem_addr[g]), .mem_read(mem_read[g]), .mem_write(mem_write[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .err_bits(err_bits[g]), .halted(halted[g])
    );

    // Memory read model: data becomes valid LAT-1 enabled edges after the strobe cycle
    // starts (combinational in the strobe cycle when LAT=1); junk before that.
    logic [31:0] rd_word;
    int          rd_age;
    always @(posedge clk) begin
      if (rst[g]) rd_age <= 16;
      else if (clk_en[g]) begin
        if (mem_read[g]) begin
          rd_word <= mem[mem_addr[g][11:2]];
          rd_age  <= 1;
        end else if (rd_age < 16) begin
          rd_age <= rd_age + 1;
        end
      end
    end
    assign mem_rdata[g] = mem_read[g] ? ((LAT == 1) ? mem[mem_addr[g][11:2]] : 32'hBAD0BAD0)
                        : ((rd_age >= LAT - 1 && rd_age < 16) ? rd_word : 32'hBAD0BAD0);
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
    end else if (clk_en[0] && mem_write[0]) begin
      mem[mem_addr[0][11:2]] <= mem_wdata[0];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic got(int g, logic ch, logic [31:0] data);
    exp_t e;
    n_cmp++;
    assert (exp_q.size() != 0)
    else begin
      n_bad++;
      $error("FAIL unexpected_valid: observed valid inst%0d ch%0d at cycle %0d expected none", g, ch, cyc);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check($sformatf("chan_i%0d", g), 32'(g * 2 + int'(ch)), 32'(e.inst * 2 + int'(e.ch)));
      if (e.chk) check($sformatf("rdata_i%0d_ch%0d", g, ch), data, e.data);
      if (e.cyc >= 0) check($sformatf("valid_cycle_i%0d_ch%0d", g, ch), 32'(cyc), 32'(e.cyc));
    end
  endtask

  // Scoreboard side: a valid counts once, on the enabled edge that ends it.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (clk_en[g]) begin
        if (mem_read[g] | mem_write[g]) strobes[g] <= strobes[g] + 1;
        if (if_valid[g]) got(g, 1'b0, if_rdata[g]);
        if (d_valid[g])  got(g, 1'b1, d_rdata[g]);
      end
    end
  end

  task automatic push(int g, logic ch, logic [31:0] data, logic chk, int c);
    exp_t e;
    e.inst = g; e.ch = ch; e.data = data; e.chk = chk; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_q(int n, int budget);
    int b = 0;
    while (exp_q.size() > n && b < budget) begin
      @(posedge clk); #1;
      b++;
    end
    n_cmp++;
    assert (exp_q.size() <= n)
    else begin
      n_bad++;
      $error("FAIL timeout: observed %0d pending expected <= %0d", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 2'b11; clk_en = 2'b11; halt = '0; if_req = '0; d_req = '0; d_we = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_init = 1'b1;
    step(); step();
    mem_init = 1'b0; rst = 2'b00;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_err_i%0d", g), 32'(err_bits[g]), 32'd0);
      check($sformatf("rst_flags_i%0d", g),
            32'({halted[g], if_valid[g], d_valid[g], mem_read[g], mem_write[g]}), 32'd0);
      check($sformatf("rst_rdata_i%0d", g), if_rdata[g] | d_rdata[g] | mem_addr[g], 32'd0);
    end

    // LAT=1 fetch of 0x10; a fetch address change after grant must be ignored.
    k = cyc; if_req[1] = 1'b1; if_addr[1] = 32'h10;
    push(1, 1'b0, 32'hDEADBEEF, 1'b1, k + 2);
    step();
    check("lat1_mem_read", 32'(mem_read[1]), 32'd1);
    check("lat1_mem_addr", mem_addr[1], 32'h10);
    if_addr[1] = 32'h44;
    wait_q(0, 10); if_req[1] = 1'b0;

    // Round-robin with both channels held: D,I,D,I... every 3 cycles.
    k = cyc; d_req[1] = 1'b1; d_addr[1] = 32'h8; if_req[1] = 1'b1; if_addr[1] = 32'hC;
    for (int i = 0; i < 8; i++)
      push(1, (i % 2 == 0), (i % 2 == 0) ? pat(2) : pat(3), 1'b1, k + 2 + 3 * i);
    wait_q(0, 40); d_req[1] = 1'b0; if_req[1] = 1'b0;

    // LAT=3 fixed data priority: both in the same cycle.
    step();
    k = cyc; d_req[0] = 1'b1; d_addr[0] = 32'h20; if_req[0] = 1'b1; if_addr[0] = 32'h10;
    push(0, 1'b1, pat(8), 1'b1, k + 4);
    push(0, 1'b0, 32'hDEADBEEF, 1'b1, k + 9);
    wait_q(1, 20); d_req[0] = 1'b0;
    wait_q(0, 20); if_req[0] = 1'b0;

    // Write to 0x24: d_rdata keeps the previous read value, then read it back.
    k = cyc; d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h24; d_wdata[0] = 32'h12345678;
    push(0, 1'b1, pat(8), 1'b1, k + 4);
    step();
    check("wr_strobe", 32'({mem_write[0], mem_read[0]}), 32'd2);
    check("wr_wdata", mem_wdata[0], 32'h12345678);
    wait_q(0, 20); d_req[0] = 1'b0; d_we[0] = 1'b0;
    step();
    k = cyc; d_req[0] = 1'b1; d_addr[0] = 32'h24;
    push(0, 1'b1, 32'h12345678, 1'b1, k + 4);
    wait_q(0, 20); d_req[0] = 1'b0;

    // Misaligned write, then out-of-range read: no strobes, fast response.
    s0 = strobes[0];
    k = cyc; d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h6;
    push(0, 1'b1, 32'h0, 1'b0, k + 1);
    wait_q(0, 10); d_req[0] = 1'b0; d_we[0] = 1'b0;
    check("err_misalign", 32'(err_bits[0]), 32'd1);
    step();
    k = cyc; d_req[0] = 1'b1; d_addr[0] = 32'h1000;
    push(0, 1'b1, 32'h0, 1'b1, k + 1);
    wait_q(0, 10); d_req[0] = 1'b0;
    check("err_both", 32'(err_bits[0]), 32'd3);
    check("err_no_strobe", 32'(strobes[0]), 32'(s0));

    // Reset in WAIT abandons the fetch and clears the sticky errors.
    k = cyc; if_req[0] = 1'b1; if_addr[0] = 32'h40;
    step(); step();
    rst[0] = 1'b1; if_req[0] = 1'b0;
    step();
    rst[0] = 1'b0;
    check("rst_mid_err", 32'(err_bits[0]), 32'd0);
    check("rst_mid_flags", 32'({if_valid[0], mem_read[0], halted[0]}), 32'd0);
    repeat (5) step();
    k = cyc; if_req[0] = 1'b1;
    push(0, 1'b0, pat(16), 1'b1, k + 4);
    wait_q(0, 20); if_req[0] = 1'b0;

    // clk_en low for 5 edges in WAIT stretches latency by exactly 5.
    k = cyc; if_req[0] = 1'b1; if_addr[0] = 32'h14;
    push(0, 1'b0, pat(5), 1'b1, k + 9);
    step(); step();
    clk_en[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 clk_en[0] = 1'b1;
    wait_q(0, 20); if_req[0] = 1'b0;

    // Halt during WAIT: fetch still completes, then nothing more is issued.
    k = cyc; if_req[0] = 1'b1; if_addr[0] = 32'h40;
    push(0, 1'b0, pat(16), 1'b1, k + 4);
    step(); step();
    halt[0] = 1'b1;
    step();
    halt[0] = 1'b0;
    check("halt_not_yet", 32'(halted[0]), 32'd0);
    wait_q(0, 20); if_req[0] = 1'b0;
    check("halted_set", 32'(halted[0]), 32'd1);
    s0 = strobes[0];
    d_req[0] = 1'b1; d_addr[0] = 32'h8;
    repeat (10) step();
    d_req[0] = 1'b0;
    check("halted_no_strobe", 32'(strobes[0]), 32'(s0));
    check("halted_hold", 32'(halted[0]), 32'd1);

    wait_q(0, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
